// File: rtl/seq_chk_pkg.sv
// Shared types and default sizing for the down-counter sequence checker.
package seq_chk_pkg;

   localparam int WIDTH_DEF  = 4;
   localparam int CNT_W_DEF  = 8;
   localparam int LOCK_N_DEF = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SYNC  = 2'd1,
      TRACK = 2'd2
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (reset) begin
         q <= '0;
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/count_seq_checker.sv
// Checks that a down-counter stream decrements by one (mod 2^WIDTH); all outputs registered.
// Optional latched error flag built only when SEQ_CHK_STICKY_EN is defined.
module count_seq_checker
   import seq_chk_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int CNT_W  = CNT_W_DEF,
   parameter int LOCK_N = LOCK_N_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] count_in,
   input  logic             count_valid,
   input  logic             err_clear,
   output logic             locked,
   output logic             err_pulse,
   output logic             wrap_pulse,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] wrap_count,
   output logic             err_sticky
);

   localparam int GW = (LOCK_N < 1) ? 1 : $clog2(LOCK_N + 1);
   localparam logic [GW-1:0] LOCK_V = GW'(LOCK_N);

   state_t           state, state_nx;
   logic [WIDTH-1:0] expected, exp_nx, dec;
   logic [GW-1:0]    good, good_nx;
   logic             err_hit, wrap_hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         expected   <= '0;
         good       <= '0;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         wrap_pulse <= 1'b0;
      end else begin
         state      <= state_nx;
         expected   <= exp_nx;
         good       <= good_nx;
         locked     <= (state_nx == TRACK);
         err_pulse  <= err_hit;
         wrap_pulse <= wrap_hit;
      end
   end

   always_comb begin
      state_nx = state;
      exp_nx   = expected;
      good_nx  = good;
      err_hit  = 1'b0;
      wrap_hit = 1'b0;
      dec      = count_in - 1'b1;
      if (count_valid) begin
         if (state == IDLE) begin
            exp_nx   = dec;
            good_nx  = '0;
            state_nx = SYNC;
         end else if (count_in == expected) begin
            exp_nx = dec;
            if (good != LOCK_V) begin
               good_nx = good + 1'b1;
            end
            // A match on all-ones means the previous sample was 0.
            wrap_hit = &count_in;
            if ((state == SYNC) && (good_nx == LOCK_V)) begin
               state_nx = TRACK;
            end
         end else begin
            err_hit  = (state == TRACK);
            exp_nx   = dec;
            good_nx  = '0;
            state_nx = SYNC;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (err_hit),
      .q     (err_count)
   );

   sat_counter #(.W(CNT_W)) u_wrap_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (wrap_hit),
      .q     (wrap_count)
   );

`ifdef SEQ_CHK_STICKY_EN
   logic sticky;

   // Holding through the err_pulse cycle makes a coincident clear lose.
   always_ff @(posedge clk) begin
      if (reset) begin
         sticky <= 1'b0;
      end else begin
         sticky <= err_hit | err_pulse | (sticky & ~err_clear);
      end
   end

   assign err_sticky = sticky;
`else
   logic unused_err_clear;

   assign unused_err_clear = err_clear;
   assign err_sticky       = 1'b0;
`endif

endmodule
